// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-path arbiter.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_e;

  // Depth of the TX FIFO fed by the arbiter output register.
  localparam int unsigned FIFO_DEPTH = 16;

  localparam int unsigned N_REQ_DEFAULT = 4;

  // Modular add for small index arithmetic; requires a < n and b <= n.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first set request at or above the pointer, with wrap.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [ID_W-1:0]  o_grant,
  output logic             o_any_valid
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    o_grant     = '0;
    o_any_valid = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!o_any_valid && i_req[ID_W'(wrap_add(32'(i_rr_ptr), k, N_REQ))]) begin
        o_grant     = ID_W'(wrap_add(32'(i_rr_ptr), k, N_REQ));
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locking arbiter for the UART TX byte path, with owner watchdog.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               out_valid_o,
  output logic [7:0]         out_data_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic [ID_W-1:0]    owner_o,
  output logic               timeout_o,
  output logic [ID_W-1:0]    timeout_id_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  arb_state_e      r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_timeout_id;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_timeout;
  logic [CntW-1:0] r_wd_cnt;

  logic [ID_W-1:0]  w_grant;
  logic             w_any_valid;
  logic [ID_W-1:0]  w_sel;
  logic [N_REQ-1:0] w_ready;
  logic             w_slot_free;
  logic             w_accept;
  logic [7:0]       w_sel_data;
  logic             w_sel_last;
  logic             w_owner_valid;
  logic             w_wd_expire;
  logic [ID_W-1:0]  w_owner_next;

  uart_rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .i_req      (req_valid_i),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_any_valid(w_any_valid)
  );

  // Handshake decode: one requester at most may see ready, and only when it is valid.
  always_comb begin
    w_slot_free   = !r_out_valid || out_ready_i;
    w_owner_valid = req_valid_i[r_owner];
    w_ready       = '0;
    w_sel         = r_owner;
    if (r_state == IDLE) begin
      w_sel = w_grant;
      if (w_any_valid && enable_i && w_slot_free) w_ready[w_grant] = 1'b1;
    end else if (w_owner_valid && w_slot_free) begin
      w_ready[r_owner] = 1'b1;
    end
    w_accept     = |w_ready;
    w_sel_data   = req_data_i[{w_sel, 3'b000} +: 8];
    w_sel_last   = req_last_i[w_sel];
    w_wd_expire  = (TIMEOUT_CYC != 0) && (r_wd_cnt == CntMax) && !w_owner_valid;
    w_owner_next = ID_W'(wrap_add(32'(w_sel), 1, N_REQ));
  end

  // FSM, output register and watchdog, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_timeout_id <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_timeout    <= 1'b0;
      r_wd_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;

      if (w_accept) begin
        r_out_data  <= w_sel_data;
        r_out_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          r_wd_cnt <= '0;
          if (w_accept) begin
            r_owner <= w_grant;
            if (w_sel_last) r_rr_ptr <= w_owner_next;
            else            r_state  <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept && w_sel_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_owner_next;
            r_wd_cnt <= '0;
          end else if (w_owner_valid) begin
            r_wd_cnt <= '0;
          end else if (w_wd_expire) begin
            // Stalled owner: drop the lock but let any buffered byte drain.
            r_state      <= IDLE;
            r_rr_ptr     <= w_owner_next;
            r_timeout    <= 1'b1;
            r_timeout_id <= r_owner;
            r_wd_cnt     <= '0;
          end else if (TIMEOUT_CYC != 0) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready_o  = w_ready;
  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign busy_o       = (r_state == LOCKED);
  assign owner_o      = r_owner;
  assign timeout_o    = r_timeout;
  assign timeout_id_o = r_timeout_id;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic [1:0]    owner;
  logic          timeout;
  logic [1:0]    timeout_id;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit       m_locked;
  int       m_ptr;
  int       m_owner;
  int       m_idle_run;
  bit       m_ov;
  logic [7:0] m_od;
  bit       m_to;
  int       m_toid;

  logic [N-1:0] obs_ready;

  uart_tx_arb #(
    .N_REQ      (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .owner_o     (owner),
    .timeout_o   (timeout),
    .timeout_id_o(timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which requester the arbitration rules allow to hand over a byte right now.
  function automatic logic [N-1:0] exp_ready_f(input logic [N-1:0] v, input logic en,
                                               input logic rdy);
    bit free;
    int idx;
    free = !m_ov || rdy;
    if (m_locked) begin
      if (v[m_owner] && free) return N'(1) << m_owner;
      return '0;
    end
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (v[idx]) return (en && free) ? (N'(1) << idx) : '0;
    end
    return '0;
  endfunction

  task automatic model_step(input logic [N-1:0] v, input logic [N*8-1:0] d,
                            input logic [N-1:0] l, input logic en, input logic rdy,
                            input logic rn);
    logic [N-1:0] er;
    int a;
    if (!rn) begin
      m_locked = 0; m_ptr = 0; m_owner = 0; m_idle_run = 0;
      m_ov = 0; m_od = 8'h00; m_to = 0; m_toid = 0;
      return;
    end
    er = exp_ready_f(v, en, rdy);
    a = -1;
    for (int k = 0; k < N; k++) if (er[k]) a = k;
    m_to = 0;
    if (a >= 0) begin
      m_od = d[a*8 +: 8];
      m_ov = 1;
    end else if (rdy) begin
      m_ov = 0;
    end
    if (!m_locked) begin
      if (a >= 0) begin
        m_owner = a;
        if (l[a]) m_ptr = (a + 1) % N;
        else      m_locked = 1;
      end
      m_idle_run = 0;
    end else if (a >= 0 && l[a]) begin
      m_locked = 0;
      m_ptr = (m_owner + 1) % N;
      m_idle_run = 0;
    end else if (v[m_owner]) begin
      m_idle_run = 0;
    end else if (TO != 0 && m_idle_run + 1 == TO) begin
      // The TO-th consecutive idle cycle of the owner releases the lock.
      m_locked = 0;
      m_ptr = (m_owner + 1) % N;
      m_to = 1;
      m_toid = m_owner;
      m_idle_run = 0;
    end else begin
      m_idle_run++;
    end
  endtask

  // One clock: drive on the falling edge, check ready mid-cycle, check state after the edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic [N-1:0] l,
                       input logic en, input logic rdy, input logic rn);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    req_last  = l;
    enable    = en;
    out_ready = rdy;
    rst_n     = rn;
    #1;
    obs_ready = req_ready;
    if (rn) chk("req_ready", 32'(req_ready), 32'(exp_ready_f(v, en, rdy)));
    model_step(v, d, l, en, rdy, rn);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("timeout_id", 32'(timeout_id), 32'(m_toid));
  endtask

  task automatic do_reset();
    cycle('0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  int pct[N];
  int fire;
  logic [N-1:0] ready_after;
  logic [N-1:0] rv, rl;
  logic [N*8-1:0] rd;

  initial begin
    rst_n = 1'b0; enable = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    out_ready = 1'b1;
    m_locked = 0; m_ptr = 0; m_owner = 0; m_idle_run = 0;
    m_ov = 0; m_od = 8'h00; m_to = 0; m_toid = 0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    // Round robin over single-byte messages
    for (int i = 0; i < 6; i++) begin
      cycle(4'hF, 32'hA3A2A1A0, 4'hF, 1'b1, 1'b1, 1'b1);
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_byte", 32'(out_data), 32'(8'hA0 + i % 4));
    end

    // Message lock: req1 sends 11,12,13 while req2 waits with 22
    do_reset();
    cycle(4'b0110, 32'h0022_1100, 4'b0100, 1'b1, 1'b1, 1'b1);
    chk("lock_b0", 32'(out_data), 32'h11);
    chk("lock_busy0", 32'(busy), 1);
    cycle(4'b0110, 32'h0022_1200, 4'b0100, 1'b1, 1'b1, 1'b1);
    chk("lock_b1", 32'(out_data), 32'h12);
    chk("lock_busy1", 32'(busy), 1);
    cycle(4'b0110, 32'h0022_1300, 4'b0110, 1'b1, 1'b1, 1'b1);
    chk("lock_b2", 32'(out_data), 32'h13);
    chk("lock_busy2", 32'(busy), 0);
    cycle(4'b0100, 32'h0022_0000, 4'b0100, 1'b1, 1'b1, 1'b1);
    chk("lock_b3", 32'(out_data), 32'h22);

    // Backpressure: byte held for 5 cycles, then leaves while the next is accepted
    do_reset();
    cycle(4'b0001, 32'h55, 4'b0001, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 32'h66, 4'b0001, 1'b1, 1'b0, 1'b1);
      chk("bp_ready", 32'(obs_ready), 0);
      chk("bp_hold", 32'(out_data), 32'h55);
    end
    cycle(4'b0001, 32'h66, 4'b0001, 1'b1, 1'b1, 1'b1);
    chk("bp_accept", 32'(obs_ready), 1);
    chk("bp_next", 32'(out_data), 32'h66);

    // Watchdog: req3 stalls after one byte; req0 waits
    do_reset();
    cycle(4'b1000, 32'h3000_0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    fire = -1;
    ready_after = '0;
    for (int i = 1; i <= 12; i++) begin
      cycle(4'b0001, 32'h40, 4'b0001, 1'b1, 1'b1, 1'b1);
      if (i == 9) ready_after = obs_ready;
      if (timeout && fire < 0) fire = i;
    end
    chk("wd_delay", 32'(fire), 8);
    chk("wd_id", 32'(timeout_id), 3);
    chk("wd_next_grant", 32'(ready_after), 1);

    // Enable gating
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 32'h04030201, 4'h0, 1'b0, 1'b1, 1'b1);
      chk("en_block", 32'(obs_ready), 0);
    end
    cycle(4'hF, 32'h04030201, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("en_grant", 32'(obs_ready), 1);
    cycle(4'hF, 32'h04030205, 4'h0, 1'b0, 1'b1, 1'b1);
    chk("en_mid", 32'(obs_ready), 1);
    cycle(4'hF, 32'h04030206, 4'hF, 1'b0, 1'b1, 1'b1);
    chk("en_last", 32'(obs_ready), 1);
    chk("en_done", 32'(busy), 0);
    cycle(4'hF, 32'h04030201, 4'hF, 1'b0, 1'b1, 1'b1);
    chk("en_after", 32'(obs_ready), 0);

    // Reset mid-message
    do_reset();
    cycle(4'b0010, 32'h7700, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(4'b0010, 32'h7800, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("mr_busy", 32'(busy), 1);
    chk("mr_valid", 32'(out_valid), 1);
    cycle(4'b0010, 32'h7800, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("mr_valid0", 32'(out_valid), 0);
    chk("mr_data0", 32'(out_data), 0);
    chk("mr_busy0", 32'(busy), 0);
    chk("mr_owner0", 32'(owner), 0);
    cycle(4'hF, 32'h44332211, 4'hF, 1'b1, 1'b1, 1'b1);
    chk("mr_regrant", 32'(obs_ready), 1);

    // Randomized traffic with shifting per-requester activity
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        for (int k = 0; k < N; k++) begin
          case ($urandom_range(0, 3))
            0:       pct[k] = 0;
            1:       pct[k] = 10;
            2:       pct[k] = 50;
            default: pct[k] = 90;
          endcase
        end
      end
      for (int k = 0; k < N; k++) begin
        rv[k] = ($urandom_range(0, 99) < pct[k]);
        rl[k] = ($urandom_range(0, 99) < 30);
      end
      rd = $urandom;
      cycle(rv, rd, rl, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 499) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing the single UART transmit byte path (TX FIFO write side feeding the serial transmitter) among N_REQ byte-stream requesters, e.g. CPU bus, debug monitor, boot loader.
- Supports multi-byte messages: once a requester's first byte is accepted, it owns the path until its byte marked last is accepted, so messages never interleave on tx_o.
- A watchdog releases a stalled owner.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1024, owner-idle cycles before forced release; 0 disables the watchdog.
- ID_W, $clog2(N_REQ), requester index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- enable_i  in  1  permit new grants; a low level does not abort an owned message
- req_valid_i  in  N_REQ  per-requester byte valid
- req_data_i  in  N_REQ*8  per-requester byte, requester k at [8k+7:8k]
- req_last_i  in  N_REQ  byte is the final byte of the message
- req_ready_o  out  N_REQ  byte accepted this cycle (valid & ready)
- out_valid_o  out  1  byte available to TX FIFO
- out_data_o  out  8  byte to TX FIFO
- out_ready_i  in  1  TX FIFO can accept (driven as !fifo_full)
- busy_o  out  1  FSM in LOCKED
- owner_o  out  ID_W  current or last granted requester
- timeout_o  out  1  one-cycle pulse on watchdog release
- timeout_id_o  out  ID_W  requester released by watchdog, held until next timeout

Behaviour:
- Reset (rst_n low at a clk edge), values after that edge:
  - state IDLE, rr_ptr 0, out_valid_o 0, out_data_o 0, req_ready_o 0, busy_o 0, owner_o 0, timeout_o 0, timeout_id_o 0, watchdog count 0.
  - Reset mid-message discards the output byte and the lock.
- Output register: slot_free = !out_valid_o | out_ready_i.
  - Accept: out_data_o <= selected byte, out_valid_o <= 1 next cycle. Latency is 1 cycle from acceptance to out_valid_o.
  - out_valid_o clears when out_ready_i is high and nothing is accepted that cycle.
  - Full throughput: one byte per cycle while out_ready_i stays high.
- req_ready_o is combinational and one-hot or zero; it is never high for a requester whose valid is low.
- IDLE:
  - Grant g = first requester with valid high, searching from rr_ptr upward with wrap (N_REQ-1 wraps to 0).
  - req_ready_o[g] = enable_i & slot_free.
  - On accept: owner_o <= g.
  - If req_last_i[g]: stay IDLE, rr_ptr <= (g+1) mod N_REQ.
  - Else: go to LOCKED.
- LOCKED:
  - Only the owner is eligible. req_ready_o[owner] = slot_free; enable_i is ignored.
  - Accept with last: go to IDLE, rr_ptr <= (owner+1) mod N_REQ. The next grant can occur in the following cycle.
- Watchdog (LOCKED only):
  - Count increments each cycle the owner's valid is low.
  - Count clears on any owner valid or on leaving LOCKED.
  - When count == TIMEOUT_CYC-1 and the owner's valid is still low: go to IDLE, rr_ptr <= owner+1, timeout_o = 1 for one cycle, timeout_id_o <= owner.
  - If the owner's valid rises on the same cycle the watchdog would expire, the byte is accepted if slot_free and no timeout occurs.
  - TIMEOUT_CYC=0: never fires.
  - Bytes already in the output register are still delivered after a timeout.
- Backpressure: out_ready_i low holds out_data_o stable and forces all req_ready_o low whenever out_valid_o is 1.
- Single-byte messages (last on the first byte) never enter LOCKED.

Decomposition:
- uart_pkg holds arb_state_e {IDLE, LOCKED} (logic [0:0]), the FIFO_DEPTH constant, and the default N_REQ.
- Sub-module uart_rr_pick: combinational rotate-priority encoder. Inputs req vector and rr_ptr; outputs grant index and any_valid. Instantiated once.
- The FSM, output register and watchdog live in uart_tx_arb.

Test Plan:
- Round-robin fairness: N_REQ=4, all valid, single-byte messages 0xA0..0xA3, out_ready_i=1 → out_data_o sequence A0,A1,A2,A3,A0…, one byte per cycle, first out_valid_o one cycle after the first accept.
- Message lock: req1 sends 0x11,0x12,0x13 (last on 0x13) while req2 is valid with 0x22 → output 11,12,13,22. busy_o is high from the cycle after 0x11 until 0x13 is accepted.
- Backpressure: out_ready_i low for 5 cycles with a byte held → out_data_o stable, req_ready_o all 0. The byte leaves on the first cycle out_ready_i is high, and a new accept occurs that same cycle.
- Watchdog: TIMEOUT_CYC=8, req3 sends 0x30 without last then drops valid → timeout_o pulses exactly 8 cycles after the last accept, timeout_id_o=3, and req0 is granted next.
- Enable: enable_i low with all valid → no req_ready_o. Deasserting enable_i mid-message still completes the owned message.
- Reset mid-message: assert rst_n low while LOCKED with out_valid_o=1 → after that edge all outputs are 0, and the next grant starts from requester 0.
